sipo_rx_ctrl: RTL and testbench
===============================

Name: sipo_rx_ctrl

Overview:
- Receive-side sequencer for the serial-in parallel-out shift-register datapath.
- Detects a start bit on an idle-high serial line and sequences the WIDTH-bit shift register at the bit rate.
- Checks the stop bit and presents the captured parallel word through a valid/ready handshake.
- Sits between the external serial pin and any consumer of parallel words.

Parameters:
- WIDTH, 4: data bits per frame and the parallel output width (must be ≥2).
- DIV, 4: clock cycles per serial bit (must be ≥2). HALF = floor(DIV/2).

Ports:
- clk  input  1  rising-edge clock.
- r  input  1  reset; asynchronous, active-high.
- sin  input  1  serial input; idle level is 1.
- dout  output  WIDTH  captured parallel word. The first data bit received is in dout[WIDTH-1]; the last is in dout[0].
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  high whenever state ≠ IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  sticky; a good frame was dropped because dout was still occupied.

Behaviour:
- Reset (r=1, asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE; dout=0; dout_valid=0; frame_err=0; overrun=0; busy=0.
  - Internal shift register, bit counter and divider counter all cleared.
- Frame format: start(0), WIDTH data bits, stop(1). Each bit is DIV cycles long.
- State machine (IDLE, START, DATA, STOP, BREAK):
  - IDLE: at the first edge where sin==0 (edge t), clear the divider and go to START.
  - START: at edge t+HALF, resample sin.
    - sin==0: go to DATA with bit count 0.
    - sin==1: glitch; return to IDLE with no flags raised.
  - DATA: every DIV cycles (edges t+HALF+k·DIV, k=1..WIDTH), shift: sreg <= {sreg[WIDTH-2:0], sin}. After the WIDTH-th sample, go to STOP.
  - STOP: sample sin at edge t+HALF+(WIDTH+1)·DIV.
    - sin==1: good frame; deliver it and go to IDLE.
    - sin==0: frame_err=1 for exactly one cycle; discard the word; go to BREAK.
  - BREAK: stay until sin==1 is sampled, then go to IDLE. This prevents a held-low line from retriggering.
- Delivery at the good-stop edge:
  - If dout_valid==0, or dout_valid==1 with dout_ready==1 in that same cycle: dout <= sreg and dout_valid=1.
  - Otherwise: dout and dout_valid are held, the new word is dropped, and overrun is set to 1 (sticky until reset).
- Handshake:
  - dout_valid clears on any edge where dout_valid & dout_ready, unless a delivery occurs on that same edge (valid then stays 1 with the new word).
  - dout is stable while dout_valid=1 and not accepted.
  - dout_ready is ignored when dout_valid=0.
- Latency: with start edge t, dout_valid is first seen high after edge t+HALF+(WIDTH+1)·DIV. For WIDTH=4, DIV=4 this is t+22.
- sin is treated as already synchronised to clk; any external synchroniser's delay adds to latency.
- busy is 1 in START, DATA, STOP and BREAK.

Test Plan:
- Reset behaviour: assert r mid-DATA with WIDTH=4, DIV=4 → all outputs are 0 immediately. After release with sin=1 for 20 cycles → busy=0 and no dout_valid.
- Good frame: send start, data bits 1,0,1,1, stop=1, with dout_ready=0 → dout=4'b1011 and dout_valid=1 at t+22; frame_err=0; overrun=0. Raise dout_ready for one cycle → dout_valid=0 on the next cycle.
- Glitch: drive sin=0 for 1 cycle only, then 1 → FSM returns to IDLE after HALF cycles; no dout_valid, no frame_err.
- Frame error: send data 0110 with stop=0, then hold sin=0 for 10 cycles → frame_err is a one-cycle pulse at t+22; dout_valid stays 0; busy stays 1 until sin returns to 1; no new frame starts while sin is low.
- Overrun: send frame 1001 with dout_ready=0, then frame 0011 → dout stays 4'b1001; overrun=1 and stays 1. Repeat with dout_ready=1 in the cycle of the second stop sample → dout=4'b0011, dout_valid=1, overrun=0.
- Back-to-back frames: send two frames with no idle gap after the stop bit, with dout_ready held at 1 → two separate dout_valid pulses, in order, with the correct words.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// Receive sequencer for a serial-in parallel-out datapath: start-bit detection, mid-bit sampling,
// stop-bit check and valid/ready delivery of the captured word with sticky overrun reporting.
module sipo_rx_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int HALF = DIV / 2;
    localparam int DW   = $clog2(DIV);
    localparam int BW   = $clog2(WIDTH);
    localparam logic [DW-1:0] HALF_LAST = DW'(HALF - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // The divider restarts at every sampling point, so each state only waits for its own terminal count.
    always_comb begin
        state_d = state_q;
        div_d   = div_q + DW'(1);
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;

        if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (!sin) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (div_q == HALF_LAST) begin
                    div_d = '0;
                    bit_d = '0;
                    state_d = sin ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sreg_d = {sreg_q[WIDTH-2:0], sin};
                    bit_d  = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sin) begin
                        state_d = ST_IDLE;
                        // A word being accepted this very cycle frees the slot for the new one.
                        if (!valid_q || dout_ready) begin
                            dout_d  = sreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                div_d = '0;
                if (sin) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                div_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl: stimulus pushes expected words and frame-error pulses into queues,
// a negedge monitor pops and compares them (value, arrival cycle, overrun flag) as the DUT presents them.
module tb_sipo_rx_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int HALF  = DIV / 2;
    localparam int LAT   = HALF + (WIDTH + 1) * DIV;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               cycle;
        logic             ovr;
    } exp_t;

    logic             clk = 1'b0;
    logic             r;
    logic             sin;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t wordQ[$];
    int   errQ[$];
    exp_t monEntry;
    int   monErrCycle;
    logic prevV = 1'b0;
    logic prevR = 1'b0;
    logic allBusy;

    sipo_rx_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .r          (r),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one full frame MSB-first; optionally raises dout_ready only for the stop-sample cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic stopBit,
                                 input logic [WIDTH-1:0] expWord, input logic expectWord,
                                 input logic expOvr, input logic readyAtStop);
        int   tStart;
        exp_t e;
        tStart = cyc + 1;
        if (expectWord) begin
            e.word  = expWord;
            e.cycle = tStart + LAT;
            e.ovr   = expOvr;
            wordQ.push_back(e);
        end
        if (!stopBit) begin
            errQ.push_back(tStart + LAT);
        end
        sin = 1'b0;
        tick(DIV);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sin = data[i];
            tick(DIV);
        end
        sin = stopBit;
        tick(HALF);
        if (readyAtStop) dout_ready = 1'b1;
        tick(1);
        if (readyAtStop) dout_ready = 1'b0;
        tick(DIV - HALF - 1);
    endtask

    // A word counts as newly presented when valid rises, or stays high right after a handshake.
    always @(negedge clk) begin
        if (!r) begin
            if (dout_valid && (!prevV || prevR)) begin
                if (wordQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: got %0h expected none (cycle %0d)", dout, cyc);
                end else begin
                    monEntry = wordQ.pop_front();
                    checkOutput("word_value", 32'(dout), 32'(monEntry.word));
                    checkOutput("word_cycle", cyc, monEntry.cycle);
                    checkOutput("word_overrun", 32'(overrun), 32'(monEntry.ovr));
                end
            end
            if (frame_err) begin
                if (errQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_frame_err: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    monErrCycle = errQ.pop_front();
                    checkOutput("frame_err_cycle", cyc, monErrCycle);
                end
            end
        end
        prevV = dout_valid;
        prevR = dout_ready;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        r          = 1'b1;
        sin        = 1'b1;
        dout_ready = 1'b0;
        tick(3);
        checkOutput("reset_dout", 32'(dout), 0);
        checkOutput("reset_valid", 32'(dout_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_ferr", 32'(frame_err), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        r = 1'b0;
        tick(3);

        $display("[TB] good frame 1011");
        applyStimulus(4'b1011, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        checkOutput("good_valid_held", 32'(dout_valid), 1);
        checkOutput("good_dout", 32'(dout), 32'(4'b1011));
        checkOutput("good_ferr", 32'(frame_err), 0);
        checkOutput("good_overrun", 32'(overrun), 0);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        checkOutput("good_valid_cleared", 32'(dout_valid), 0);

        $display("[TB] glitch");
        tick(2);
        sin = 1'b0;
        tick(1);
        sin = 1'b1;
        checkOutput("glitch_busy", 32'(busy), 1);
        tick(HALF);
        checkOutput("glitch_idle", 32'(busy), 0);
        tick(10);
        checkOutput("glitch_no_valid", 32'(dout_valid), 0);

        $display("[TB] frame error 0110");
        applyStimulus(4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("ferr_pulse_end", 32'(frame_err), 0);
        allBusy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!busy || dout_valid) allBusy = 1'b0;
        end
        checkOutput("ferr_break_held", 32'(allBusy), 1);
        sin = 1'b1;
        tick(1);
        checkOutput("ferr_break_exit", 32'(busy), 0);
        checkOutput("ferr_no_valid", 32'(dout_valid), 0);
        tick(4);

        $display("[TB] overrun 1001 then 0011");
        applyStimulus(4'b1001, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_dout", 32'(dout), 32'(4'b1001));
        checkOutput("ovr_valid", 32'(dout_valid), 1);
        checkOutput("ovr_flag", 32'(overrun), 1);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        tick(3);
        checkOutput("ovr_sticky", 32'(overrun), 1);
        checkOutput("ovr_valid_cleared", 32'(dout_valid), 0);

        $display("[TB] reset mid-frame");
        sin = 1'b0;
        tick(DIV);
        sin = 1'b1;
        tick(DIV);
        sin = 1'b0;
        tick(2);
        #2;
        r = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_dout", 32'(dout), 0);
        checkOutput("rst_valid", 32'(dout_valid), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_ferr", 32'(frame_err), 0);
        tick(2);
        sin = 1'b1;
        r   = 1'b0;
        tick(20);
        checkOutput("rst_after_busy", 32'(busy), 0);
        checkOutput("rst_after_valid", 32'(dout_valid), 0);

        $display("[TB] overrun avoided by ready at stop");
        applyStimulus(4'b1001, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b1);
        checkOutput("rep_overrun", 32'(overrun), 0);
        checkOutput("rep_dout", 32'(dout), 32'(4'b0011));
        checkOutput("rep_valid", 32'(dout_valid), 1);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        tick(2);

        $display("[TB] back-to-back frames");
        dout_ready = 1'b1;
        applyStimulus(4'b1100, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
        tick(3);
        dout_ready = 1'b0;
        checkOutput("b2b_valid_cleared", 32'(dout_valid), 0);

        tick(5);
        checkOutput("wordq_drained", wordQ.size(), 0);
        checkOutput("errq_drained", errQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
